// File: rtl/lane_fifo_pkg.sv
// Shared constants and sizing helpers for lane_fifo and its storage array.
package lane_fifo_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned DEPTH_DEF  = 8;
    localparam int unsigned DEPTH_MIN  = 4;
    localparam int unsigned AF_THR_DEF = 6;
    localparam int unsigned AE_THR_DEF = 2;

    function automatic int unsigned ptr_w(input int unsigned depth);
        int unsigned w;
        w = 0;
        while ((32'd1 << w) < depth) w++;
        return w;
    endfunction

    function automatic int unsigned lvl_w(input int unsigned depth);
        return ptr_w(depth) + 1;
    endfunction

    // Thresholds must fit inside the level range and keep the two flags ordered.
    function automatic bit cfg_ok(input int unsigned depth, input int unsigned af,
                                  input int unsigned ae);
        return (depth >= DEPTH_MIN) && ((depth & (depth - 1)) == 0) &&
               (af <= depth) && (ae < af);
    endfunction

endpackage

// File: rtl/lane_fifo_mem.sv
// DEPTH x DATA_W storage: one synchronous write port, one asynchronous read port, no reset.
module lane_fifo_mem
    import lane_fifo_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned PTR_W  = ptr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [PTR_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [PTR_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/lane_fifo.sv
// Per-lane elastic FIFO with registered read data, level/watermark flags and error pulses.
// Optional saturating error counter output err_cnt when LANE_FIFO_ERR_CNT_EN is defined.
module lane_fifo
    import lane_fifo_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned AF_THR = AF_THR_DEF,
    parameter int unsigned AE_THR = AE_THR_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_W-1:0]        data_in,
    input  logic                     push,
    input  logic                     pop,
    output logic [DATA_W-1:0]        data_out,
    output logic                     valid_out,
    output logic [lvl_w(DEPTH)-1:0]  fill_level,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic                     overflow,
    output logic                     underflow
`ifdef LANE_FIFO_ERR_CNT_EN
   ,output logic [7:0]               err_cnt
`endif
);

    localparam int unsigned PTR_W = ptr_w(DEPTH);
    localparam int unsigned LVL_W = lvl_w(DEPTH);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] LVL_AF   = LVL_W'(AF_THR);
    localparam logic [LVL_W-1:0] LVL_AE   = LVL_W'(AE_THR);

    if (!cfg_ok(DEPTH, AF_THR, AE_THR)) begin : g_bad_cfg
        $error("lane_fifo: illegal DEPTH/AF_THR/AE_THR combination");
    end

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [DATA_W-1:0] rd_data;
    logic              do_push;
    logic              do_pop;

    assign full         = (fill_level == LVL_FULL);
    assign empty        = (fill_level == '0);
    assign almost_full  = (fill_level >= LVL_AF);
    assign almost_empty = (fill_level <= LVL_AE);

    // A pop in the same cycle frees the slot a full FIFO needs for the push.
    always_comb begin
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
    end

    lane_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (do_push && !reset),
        .waddr (wr_ptr),
        .wdata (data_in),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_level <= '0;
            data_out   <= '0;
            valid_out  <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            valid_out <= do_pop;
            overflow  <= push && !do_push;
            underflow <= pop && !do_pop;
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop) begin
                rd_ptr   <= rd_ptr + PTR_W'(1);
                data_out <= rd_data;
            end
            case ({do_push, do_pop})
                2'b10:   fill_level <= fill_level + LVL_W'(1);
                2'b01:   fill_level <= fill_level - LVL_W'(1);
                default: fill_level <= fill_level;
            endcase
        end
    end

`ifdef LANE_FIFO_ERR_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            err_cnt <= '0;
        end else if ((overflow || underflow) && (err_cnt != '1)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_lane_fifo.sv
// Directed, table-driven bench for lane_fifo (DEPTH=8, AF_THR=6, AE_THR=2).
module tb_lane_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic       push;
    logic       pop;
    logic [7:0] data_out;
    logic       valid_out;
    logic [3:0] fill_level;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;
`ifdef LANE_FIFO_ERR_CNT_EN
    logic [7:0] err_cnt;
`endif

    int unsigned checks   = 0;
    int unsigned failures = 0;

    always #5 clk = ~clk;

    lane_fifo #(
        .DATA_W (8),
        .DEPTH  (8),
        .AF_THR (6),
        .AE_THR (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .data_in      (data_in),
        .push         (push),
        .pop          (pop),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .fill_level   (fill_level),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
`ifdef LANE_FIFO_ERR_CNT_EN
       ,.err_cnt      (err_cnt)
`endif
    );

    typedef struct {
        logic       push;
        logic       pop;
        logic [7:0] din;
        logic [7:0] dout;
        logic       vld;
        logic [3:0] lvl;
        logic       ovf;
        logic       udf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic p, input logic r, input logic [7:0] din,
                                input logic [7:0] dout, input logic vld,
                                input logic [3:0] lvl, input logic ovf, input logic udf);
        vec_t v;
        v.push = p; v.pop = r; v.din = din; v.dout = dout;
        v.vld = vld; v.lvl = lvl; v.ovf = ovf; v.udf = udf;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic p, input logic r, input logic [7:0] d);
        push = p; pop = r; data_in = d;
        @(posedge clk);
        #1;
    endtask

    // Flags are checked against the level the bench expects, using the fixed thresholds.
    task automatic chk_flags(input string tag, input logic [3:0] lvl);
        chk({tag, ".full"},  {31'd0, full},         {31'd0, lvl == 4'd8});
        chk({tag, ".empty"}, {31'd0, empty},        {31'd0, lvl == 4'd0});
        chk({tag, ".af"},    {31'd0, almost_full},  {31'd0, lvl >= 4'd6});
        chk({tag, ".ae"},    {31'd0, almost_empty}, {31'd0, lvl <= 4'd2});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        reset = 1'b0;
    endtask

    // Queue-model stream: pushes on cycles 0..19, pops on cycles off..off+19.
    task automatic run_stream(input int unsigned off, input logic [7:0] base);
        logic [7:0]  q[$];
        logic [7:0]  exp_d;
        logic        p, r, vld;
        int unsigned sz;
        exp_d = 8'h00;
        for (int i = 0; i < 20 + int'(off) + 1; i++) begin
            p   = (i < 20);
            r   = (i >= int'(off)) && (i < 20 + int'(off));
            sz  = q.size();
            vld = r && (sz > 0);
            if (vld) exp_d = q.pop_front();
            if (p && (sz < 8 || vld)) q.push_back(base + 8'(i));
            step(p, r, base + 8'(i));
            chk("stream.valid", {31'd0, valid_out}, {31'd0, vld});
            if (vld) chk("stream.data", {24'd0, data_out}, {24'd0, exp_d});
            chk("stream.level", {28'd0, fill_level}, 32'(q.size()));
            chk_flags("stream", 4'(q.size()));
        end
    endtask

    initial begin
        vec_t v;
        reset = 1'b0; push = 1'b0; pop = 1'b0; data_in = 8'h00;

        // Push/pop/data table: in-order read, empty push+pop, overflow, full push+pop.
        vecs.push_back(mk(1, 0, 8'hA1, 8'h00, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 8'hA2, 8'h00, 0, 2, 0, 0));
        vecs.push_back(mk(1, 0, 8'hA3, 8'h00, 0, 3, 0, 0));
        vecs.push_back(mk(0, 1, 8'h00, 8'hA1, 1, 2, 0, 0));
        vecs.push_back(mk(0, 1, 8'h00, 8'hA2, 1, 1, 0, 0));
        vecs.push_back(mk(0, 1, 8'h00, 8'hA3, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 8'hA3, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 8'h33, 8'hA3, 0, 1, 0, 1));
        vecs.push_back(mk(0, 1, 8'h00, 8'h33, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h00, 8'h33, 0, 0, 0, 1));
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(1, 0, 8'hB0 + 8'(i), 8'h33, 0, 4'(i + 1), 0, 0));
        vecs.push_back(mk(1, 0, 8'hB8, 8'h33, 0, 8, 1, 0));
        vecs.push_back(mk(1, 1, 8'h5C, 8'hB0, 1, 8, 0, 0));
        for (int i = 1; i < 8; i++)
            vecs.push_back(mk(0, 1, 8'h00, 8'hB0 + 8'(i), 1, 4'(8 - i), 0, 0));
        vecs.push_back(mk(0, 1, 8'h00, 8'h5C, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h00, 8'h5C, 0, 0, 0, 1));

        do_reset();
        chk("reset.level", {28'd0, fill_level}, 32'd0);
        chk("reset.data",  {24'd0, data_out},   32'd0);
        chk("reset.valid", {31'd0, valid_out},  32'd0);
        chk("reset.ovf",   {31'd0, overflow},   32'd0);
        chk("reset.udf",   {31'd0, underflow},  32'd0);
        chk_flags("reset", 4'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            step(v.push, v.pop, v.din);
            chk($sformatf("vec%0d.data", i),  {24'd0, data_out},   {24'd0, v.dout});
            chk($sformatf("vec%0d.valid", i), {31'd0, valid_out},  {31'd0, v.vld});
            chk($sformatf("vec%0d.level", i), {28'd0, fill_level}, {28'd0, v.lvl});
            chk($sformatf("vec%0d.ovf", i),   {31'd0, overflow},   {31'd0, v.ovf});
            chk($sformatf("vec%0d.udf", i),   {31'd0, underflow},  {31'd0, v.udf});
            chk_flags($sformatf("vec%0d", i), v.lvl);
        end
        step(0, 0, 8'h00);

        // Pointer wrap with a 1-cycle and a 6-cycle push-to-pop offset.
        run_stream(1, 8'h10);
        run_stream(6, 8'h40);
        chk("stream.end_empty", {31'd0, empty}, 32'd1);

        // Reset with five entries held, push and pop both requested.
        for (int i = 0; i < 5; i++) step(1, 0, 8'hC0 + 8'(i));
        step(0, 1, 8'h00);
        chk("prerst.data", {24'd0, data_out}, 32'hC0);
        chk("prerst.level", {28'd0, fill_level}, 32'd4);
        step(1, 0, 8'hC5);
        chk("prerst.level5", {28'd0, fill_level}, 32'd5);
        reset = 1'b1;
        step(1, 1, 8'hEE);
        reset = 1'b0;
        chk("midrst.level", {28'd0, fill_level}, 32'd0);
        chk("midrst.data",  {24'd0, data_out},   32'd0);
        chk("midrst.valid", {31'd0, valid_out},  32'd0);
        chk_flags("midrst", 4'd0);
        step(0, 1, 8'h00);
        chk("midrst.udf", {31'd0, underflow}, 32'd1);
        chk("midrst.novalid", {31'd0, valid_out}, 32'd0);
        step(0, 0, 8'h00);
        chk("udf.pulse_end", {31'd0, underflow}, 32'd0);

        do_reset();
        for (int i = 0; i < 8; i++) step(1, 0, 8'h70 + 8'(i));
        chk("ovfrun.full", {31'd0, full}, 32'd1);
        for (int i = 0; i < 300; i++) step(1, 0, 8'hFF);
        chk("ovfrun.ovf", {31'd0, overflow}, 32'd1);
        chk("ovfrun.level", {28'd0, fill_level}, 32'd8);
        step(0, 1, 8'h00);
        chk("ovfrun.oldest", {24'd0, data_out}, 32'h70);
        chk("ovfrun.ovf_clear", {31'd0, overflow}, 32'd0);
`ifdef LANE_FIFO_ERR_CNT_EN
        chk("errcnt.sat", {24'd0, err_cnt}, 32'hFF);
        do_reset();
        chk("errcnt.reset", {24'd0, err_cnt}, 32'd0);
        step(0, 1, 8'h00);
        step(1, 1, 8'h01);
        chk("errcnt.one_udf", {24'd0, err_cnt}, 32'd1);
        step(0, 0, 8'h00);
        chk("errcnt.two_udf", {24'd0, err_cnt}, 32'd2);
`else
        do_reset();
`endif
        chk("final.empty", {31'd0, empty}, {31'd0, fill_level == 4'd0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
